// File: rtl/delay_slot_scheduler_if.sv
// Requester-side bundle of the shared delay timer: requests and delays in,
// grant/done/status out.
interface delay_slot_scheduler_if #(
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2,
  parameter int DELAY_WIDTH = 16
);
  logic [NUM_REQ-1:0]             REQ;
  logic [NUM_REQ*DELAY_WIDTH-1:0] DELAY;
  logic [NUM_REQ-1:0]             GRANT;
  logic [NUM_REQ-1:0]             DONE;
  logic                           BUSY;
  logic [ID_WIDTH-1:0]            ACTIVE_ID;
  logic [DELAY_WIDTH-1:0]         REMAINING;

  modport master (output REQ, DELAY,
                  input  GRANT, DONE, BUSY, ACTIVE_ID, REMAINING);
  modport slave  (input  REQ, DELAY,
                  output GRANT, DONE, BUSY, ACTIVE_ID, REMAINING);
endinterface

// File: rtl/delay_slot_scheduler.sv
// Round-robin scheduler for one shared prescaled down-counter timer.
// Optional macro DELAY_SLOT_ABORT_EN: dropping REQ mid-wait aborts it without DONE.
module delay_slot_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int ID_WIDTH     = 2,
  parameter int DELAY_WIDTH  = 16,
  parameter int PRESCALE_MAX = 99
) (
  input logic CLK,
  input logic RESET,
  delay_slot_scheduler_if.slave bus
);
  localparam int PS_W = (PRESCALE_MAX > 0) ? $clog2(PRESCALE_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic                   busy_q, busy_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic [ID_WIDTH-1:0]    last_q, last_d;
  logic [DELAY_WIDTH-1:0] rem_q, rem_d;
  logic [PS_W-1:0]        ps_q, ps_d;

  logic                   found;
  int                     win_idx;
  int                     idx;
  logic [DELAY_WIDTH-1:0] win_dly;
  logic                   tick;

  // Scan from farthest to nearest so the nearest requester after last_q wins.
  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.REQ[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
    win_dly = bus.DELAY[win_idx*DELAY_WIDTH +: DELAY_WIDTH];
  end

  assign tick = (ps_q == PS_W'(PRESCALE_MAX));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    id_d    = id_q;
    last_d  = last_q;
    rem_d   = rem_q;
    ps_d    = ps_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          id_d   = ID_WIDTH'(win_idx);
          last_d = ID_WIDTH'(win_idx);
          rem_d  = win_dly;
          ps_d   = '0;
          if (win_dly != '0) begin
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            state_d          = RUN;
          end else begin
            done_d[win_idx] = 1'b1;
            state_d         = FINISH;
          end
        end
      end
      RUN: begin
`ifdef DELAY_SLOT_ABORT_EN
        if (!bus.REQ[id_q]) begin
          state_d = IDLE;
          grant_d = '0;
          rem_d   = '0;
          ps_d    = '0;
        end else
`endif
        if (tick) begin
          ps_d = '0;
          if (rem_q == DELAY_WIDTH'(1)) begin
            rem_d        = '0;
            grant_d      = '0;
            done_d[id_q] = 1'b1;
            state_d      = FINISH;
          end else if (rem_q != '0) begin
            rem_d = rem_q - DELAY_WIDTH'(1);
          end
        end else begin
          ps_d = ps_q + PS_W'(1);
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      id_q    <= '0;
      last_q  <= ID_WIDTH'(NUM_REQ - 1);
      rem_q   <= '0;
      ps_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      id_q    <= id_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      ps_q    <= ps_d;
    end
  end

  assign bus.GRANT     = grant_q;
  assign bus.DONE      = done_q;
  assign bus.BUSY      = busy_q;
  assign bus.ACTIVE_ID = id_q;
  assign bus.REMAINING = rem_q;
endmodule

// File: tb/tb_delay_slot_scheduler.sv
// Directed bench for delay_slot_scheduler: two instances, PRESCALE_MAX=3 and 0.
module tb_delay_slot_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  delay_slot_scheduler_if #(.NUM_REQ(4), .ID_WIDTH(2), .DELAY_WIDTH(16)) bus1 ();
  delay_slot_scheduler_if #(.NUM_REQ(4), .ID_WIDTH(2), .DELAY_WIDTH(16)) bus2 ();

  delay_slot_scheduler #(.NUM_REQ(4), .ID_WIDTH(2), .DELAY_WIDTH(16), .PRESCALE_MAX(3))
    dut1 (.CLK(clk), .RESET(rst), .bus(bus1));
  delay_slot_scheduler #(.NUM_REQ(4), .ID_WIDTH(2), .DELAY_WIDTH(16), .PRESCALE_MAX(0))
    dut2 (.CLK(clk), .RESET(rst), .bus(bus2));

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int viol   = 0;
  int g2_cnt = 0;
  int d2_cnt = 0;
  int wrap2  = 0;
  logic [15:0] rem2_prev  = '0;
  logic        busy2_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one cycle; sample #1 after the edge and update running monitors.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if ($countones(bus1.GRANT) > 1 || $countones(bus1.DONE) > 1 || (|(bus1.GRANT & bus1.DONE)))
      viol++;
    if (bus2.GRANT[0]) g2_cnt++;
    if (bus2.DONE != 4'b0) d2_cnt++;
    if (busy2_prev && rem2_prev == 16'h0 && bus2.REMAINING == 16'hFFFF) wrap2++;
    rem2_prev  = bus2.REMAINING;
    busy2_prev = bus2.BUSY;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus1.REQ  = '0;
    bus2.REQ  = '0;
    step();
    step();
    rst    = 1'b0;
    cyc    = 0;
    g2_cnt = 0;
    d2_cnt = 0;
    wrap2  = 0;
  endtask

  task automatic set_dly(input int i, input logic [15:0] v);
    bus1.DELAY[i*16 +: 16] = v;
  endtask

  initial begin
    bus1.REQ = '0; bus1.DELAY = '0;
    bus2.REQ = '0; bus2.DELAY = '0;

    // Reset state
    do_reset();
    chk("rst_grant", 32'(bus1.GRANT), 32'h0);
    chk("rst_done",  32'(bus1.DONE), 32'h0);
    chk("rst_busy",  32'(bus1.BUSY), 32'h0);
    chk("rst_id",    32'(bus1.ACTIVE_ID), 32'h0);
    chk("rst_rem",   32'(bus1.REMAINING), 32'h0);

    // Single requester, delay 5
    bus1.REQ = 4'b0001; set_dly(0, 16'd5);
    goto(1);
    chk("s1_grant_c1", 32'(bus1.GRANT), 32'h1);
    chk("s1_rem_c1",   32'(bus1.REMAINING), 32'd5);
    chk("s1_busy_c1",  32'(bus1.BUSY), 32'h1);
    goto(4);  chk("s1_rem_c4",  32'(bus1.REMAINING), 32'd5);
    goto(5);  chk("s1_rem_c5",  32'(bus1.REMAINING), 32'd4);
    goto(20);
    chk("s1_grant_c20", 32'(bus1.GRANT), 32'h1);
    chk("s1_rem_c20",   32'(bus1.REMAINING), 32'd1);
    goto(21);
    chk("s1_done_c21",  32'(bus1.DONE), 32'h1);
    chk("s1_grant_c21", 32'(bus1.GRANT), 32'h0);
    chk("s1_rem_c21",   32'(bus1.REMAINING), 32'd0);
    bus1.REQ = 4'b0000;
    goto(22);
    chk("s1_busy_c22", 32'(bus1.BUSY), 32'h0);
    chk("s1_done_c22", 32'(bus1.DONE), 32'h0);

    // All requesting, delay 1: round-robin with a 6-cycle period
    do_reset();
    bus1.REQ = 4'b1111;
    for (int i = 0; i < 4; i++) set_dly(i, 16'd1);
    goto(1);  chk("rr_g0", 32'(bus1.GRANT), 32'h1); chk("rr_id0", 32'(bus1.ACTIVE_ID), 32'd0);
    goto(5);  chk("rr_done0", 32'(bus1.DONE), 32'h1);
    goto(6);  chk("rr_idle_grant", 32'(bus1.GRANT), 32'h0); chk("rr_idle_busy", 32'(bus1.BUSY), 32'h0);
    goto(7);  chk("rr_g1", 32'(bus1.GRANT), 32'h2); chk("rr_id1", 32'(bus1.ACTIVE_ID), 32'd1);
    goto(11); chk("rr_done1", 32'(bus1.DONE), 32'h2);
    goto(13); chk("rr_g2", 32'(bus1.GRANT), 32'h4); chk("rr_id2", 32'(bus1.ACTIVE_ID), 32'd2);
    goto(19); chk("rr_g3", 32'(bus1.GRANT), 32'h8); chk("rr_id3", 32'(bus1.ACTIVE_ID), 32'd3);
    goto(25); chk("rr_g0b", 32'(bus1.GRANT), 32'h1); chk("rr_id0b", 32'(bus1.ACTIVE_ID), 32'd0);
    bus1.REQ = 4'b0000;
    goto(32);

    // Zero delay: straight to DONE, no GRANT
    do_reset();
    bus1.REQ = 4'b0100; set_dly(2, 16'd0);
    goto(1);
    chk("z_done",  32'(bus1.DONE), 32'h4);
    chk("z_grant", 32'(bus1.GRANT), 32'h0);
    chk("z_id",    32'(bus1.ACTIVE_ID), 32'd2);
    chk("z_busy",  32'(bus1.BUSY), 32'h1);
    bus1.REQ = 4'b0000;
    goto(2);
    chk("z_done_off", 32'(bus1.DONE), 32'h0);
    chk("z_busy_off", 32'(bus1.BUSY), 32'h0);

    // REQ dropped mid-wait
    do_reset();
    bus1.REQ = 4'b0010; set_dly(1, 16'd10);
    goto(8);
    chk("ab_grant_c8", 32'(bus1.GRANT), 32'h2);
    bus1.REQ = 4'b0000;
    goto(9);
`ifdef DELAY_SLOT_ABORT_EN
    chk("ab_grant_c9", 32'(bus1.GRANT), 32'h0);
    chk("ab_busy_c9",  32'(bus1.BUSY), 32'h0);
    chk("ab_rem_c9",   32'(bus1.REMAINING), 32'h0);
    goto(41);
    chk("ab_nodone_c41", 32'(bus1.DONE), 32'h0);
`else
    chk("ab_grant_c9",  32'(bus1.GRANT), 32'h2);
    goto(40);
    chk("ab_grant_c40", 32'(bus1.GRANT), 32'h2);
    goto(41);
    chk("ab_done_c41",  32'(bus1.DONE), 32'h2);
`endif
    goto(44);

    // Reset mid-wait on requester 3
    do_reset();
    bus1.REQ = 4'b1001; set_dly(0, 16'd0); set_dly(3, 16'd10);
    goto(1);  chk("mr_done0", 32'(bus1.DONE), 32'h1);
    goto(3);
    chk("mr_grant3", 32'(bus1.GRANT), 32'h8);
    chk("mr_id3",    32'(bus1.ACTIVE_ID), 32'd3);
    chk("mr_rem3",   32'(bus1.REMAINING), 32'd10);
    goto(10);
    rst = 1'b1; set_dly(0, 16'd2);
    goto(11);
    chk("mr_grant", 32'(bus1.GRANT), 32'h0);
    chk("mr_done",  32'(bus1.DONE), 32'h0);
    chk("mr_busy",  32'(bus1.BUSY), 32'h0);
    chk("mr_id",    32'(bus1.ACTIVE_ID), 32'h0);
    chk("mr_rem",   32'(bus1.REMAINING), 32'h0);
    rst = 1'b0;
    goto(12);
    chk("mr_regrant0", 32'(bus1.GRANT), 32'h1);
    chk("mr_reid0",    32'(bus1.ACTIVE_ID), 32'd0);
    chk("mr_rerem0",   32'(bus1.REMAINING), 32'd2);
    bus1.REQ = 4'b0000;
    goto(20);
    chk("onehot_viol", 32'(viol), 32'd0);

    // PRESCALE_MAX=0, maximum delay
    do_reset();
    bus2.REQ = 4'b0001; bus2.DELAY[15:0] = 16'hFFFF;
    goto(1);
    chk("mx_grant_c1", 32'(bus2.GRANT), 32'h1);
    chk("mx_rem_c1",   32'(bus2.REMAINING), 32'hFFFF);
    goto(65535);
    chk("mx_grant_last", 32'(bus2.GRANT), 32'h1);
    chk("mx_rem_last",   32'(bus2.REMAINING), 32'd1);
    goto(65536);
    chk("mx_done",    32'(bus2.DONE), 32'h1);
    chk("mx_grant_0", 32'(bus2.GRANT), 32'h0);
    chk("mx_rem_0",   32'(bus2.REMAINING), 32'h0);
    bus2.REQ = 4'b0000;
    goto(65540);
    chk("mx_grant_cnt", 32'(g2_cnt), 32'd65535);
    chk("mx_done_cnt",  32'(d2_cnt), 32'd1);
    chk("mx_wrap",      32'(wrap2), 32'd0);
    chk("mx_rem_end",   32'(bus2.REMAINING), 32'h0);
    chk("mx_busy_end",  32'(bus2.BUSY), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/delay_slot_scheduler.md
# delay_slot_scheduler

Shares one prescaled down-counter timer between several requesters in the PS/2 mouse subsystem, for example the host-to-device inhibit delay, the watchdog timeout and the display refresh hold-off. Access is granted round-robin. Each grant loads that requester's delay, counts it down in prescaler ticks, and reports completion with a one-cycle DONE pulse. The block sits between the protocol FSMs and the shared counter resource, so only one timed wait is in flight at a time.

## Interface
- NUM_REQ, 4: number of requesters.
- ID_WIDTH, 2: width of ACTIVE_ID; must satisfy 2^ID_WIDTH >= NUM_REQ.
- DELAY_WIDTH, 16: width of each delay value and of REMAINING.
- PRESCALE_MAX, 99: prescaler terminal value; one tick every PRESCALE_MAX+1 clocks (1 µs at 100 MHz).
- CLK  in  1  clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  NUM_REQ  request per requester; held high until DONE.
- DELAY  in  NUM_REQ*DELAY_WIDTH  packed delays in ticks; slice i = DELAY[i*DELAY_WIDTH +: DELAY_WIDTH]; sampled only at grant.
- GRANT  out  NUM_REQ  one-hot; high while that requester's wait runs.
- DONE  out  NUM_REQ  one-hot, one-cycle completion pulse.
- BUSY  out  1  high in any state other than IDLE.
- ACTIVE_ID  out  ID_WIDTH  index of the current or most recent grant.
- REMAINING  out  DELAY_WIDTH  ticks left in the current wait.

## Operation
- States:
  - IDLE: no wait in progress.
  - RUN: prescaler and tick counter running.
  - FINISH: one cycle that drives the DONE pulse.
- Reset: state IDLE; GRANT, DONE, BUSY, ACTIVE_ID, REMAINING and prescaler all 0. The last-served pointer is set to NUM_REQ-1, so requester 0 has first priority.
- Arbitration happens only in IDLE:
  - Search order starts at (last+1) mod NUM_REQ and wraps.
  - The first requester with REQ high wins.
- IDLE with a winner w, at the next edge:
  - ACTIVE_ID=w, REMAINING=DELAY_w, prescaler=0, last=w.
  - If DELAY_w != 0: GRANT[w]=1, go to RUN.
  - If DELAY_w == 0: go directly to FINISH; GRANT is never asserted.
- RUN:
  - Prescaler counts 0..PRESCALE_MAX, then wraps to 0.
  - A tick occurs when prescaler == PRESCALE_MAX.
  - On a tick with REMAINING == 1: REMAINING becomes 0, GRANT is cleared, go to FINISH.
  - On any other tick: REMAINING decrements by 1.
- FINISH: DONE[ACTIVE_ID]=1 for exactly this cycle, then go to IDLE. REQ still high in the following IDLE counts as a new request and takes part in normal arbitration.
- Arithmetic: REMAINING never underflows; it is never decremented from 0. Prescaler width is sized to hold PRESCALE_MAX.
- RESET asserted mid-wait aborts at the next edge: all outputs 0, no DONE pulse, pointer back to NUM_REQ-1.

## Timing
- REQ sampled in cycle t:
  - GRANT high in cycles t+1 .. t+D*(PRESCALE_MAX+1).
  - DONE in cycle t+D*(PRESCALE_MAX+1)+1.
- Zero delay: DONE in cycle t+1.
- Back-to-back grants: the pattern is FINISH, then one IDLE cycle, then the next GRANT. Minimum gap is 2 cycles from GRANT falling to the next GRANT rising.
- DONE and GRANT are never high in the same cycle.
- At most one GRANT bit and at most one DONE bit is high at any time.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- Macro DELAY_SLOT_ABORT_EN:
  - Defined: if REQ[ACTIVE_ID] is low in any RUN cycle, the next edge forces IDLE with GRANT=0 and REMAINING=0, and no DONE pulse is produced. The pointer has already advanced past the aborted requester. If the abort and the final tick fall in the same cycle, the abort wins.
  - Undefined: REQ is ignored after the grant; the wait always runs to completion and pulses DONE.

## Test plan
All scenarios use NUM_REQ=4 and PRESCALE_MAX=3 unless stated otherwise.
- REQ=0001, DELAY0=5 rising at cycle 0 -> GRANT=0001 in cycles 1–20; REMAINING steps 5,4,3,2,1,0 at every 4th edge; DONE=0001 in cycle 21; BUSY low from cycle 22.
- REQ=1111 held, all delays 1 -> grant order 0,1,2,3,0 with a 6-cycle period per grant (4 GRANT + FINISH + IDLE); ACTIVE_ID steps 0,1,2,3,0.
- REQ=0100, DELAY2=0 -> DONE=0100 in cycle 1; GRANT stays 0000; ACTIVE_ID=2.
- REQ=0010, DELAY1=10, REQ dropped at cycle 8 -> with the macro: GRANT=0000 and BUSY=0 at cycle 9, no DONE. Without the macro: DONE=0010 at cycle 41.
- RESET pulsed at cycle 10 of a DELAY=10 wait on requester 3, with REQ=1001 held -> all outputs 0 at cycle 11; requester 0 is granted first once RESET is released.
- PRESCALE_MAX=0, DELAY0=16'hFFFF -> GRANT high for 65535 cycles; REMAINING reaches 0 and never wraps to FFFF; exactly one DONE.
